// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction, data and memory-side handshake signals around mem_port_arbiter.
// master: the arbiter's view; slave: the core/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADR_W  = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADR_W-1:0]  i_adr;
  logic              i_gnt;
  logic              i_r_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic [ADR_W-1:0]  d_adr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_r_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic [ADR_W-1:0]  m_adr;
  logic              m_we;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_r_valid;
  logic [DATA_W-1:0] m_rdata;
  logic              err;

  modport master (
    input  i_req, i_adr, d_req, d_adr, d_we, d_wdata, m_gnt, m_r_valid, m_rdata,
    output i_gnt, i_r_valid, i_rdata, d_gnt, d_r_valid, d_rdata,
    output m_req, m_adr, m_we, m_wdata, err
  );

  modport slave (
    output i_req, i_adr, d_req, d_adr, d_we, d_wdata, m_gnt, m_r_valid, m_rdata,
    input  i_gnt, i_r_valid, i_rdata, d_gnt, d_r_valid, d_rdata,
    input  m_req, m_adr, m_we, m_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/r_valid memory port between instruction fetch and data load/store,
// routing responses back in grant order. Macro MEM_ARB_ROUND_ROBIN_EN enables alternating priority.
module mem_port_arbiter #(
  parameter int ADR_W       = 32,
  parameter int DATA_W      = 32,
  parameter int OUTST_DEPTH = 2
) (
  input logic                clk,
  input logic                res,
  mem_port_arbiter_if.master bus
);

  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTST_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTST_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic                   owner_r;
  logic                   owner_s;
  logic                   m_req_s;
  logic                   full_s;
  logic                   accept_s;
  logic                   pop_s;
  logic                   head_s;
  logic                   both_pick_s;
  logic                   err_r;
  logic [OUTST_DEPTH-1:0] fifo_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       cnt_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_r;

  // Remembers the most recent winner so a conflict goes to the other requester.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      last_r <= 1'b1;
    end else if (accept_s) begin
      last_r <= owner_s;
    end else begin
      last_r <= last_r;
    end
  end

  assign both_pick_s = ~last_r;
`else
  assign both_pick_s = 1'b1;
`endif

  assign full_s   = (cnt_r == FULL_CNT);
  assign accept_s = m_req_s & bus.m_gnt;
  assign pop_s    = bus.m_r_valid & (cnt_r != {CNT_W{1'b0}});
  assign head_s   = fifo_r[rd_ptr_r];

  // Arbitration and ownership lock; the full check deliberately uses the registered count.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    m_req_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (full_s) begin
          m_req_s = 1'b0;
        end else if (bus.i_req && bus.d_req) begin
          m_req_s = 1'b1;
          owner_s = both_pick_s;
        end else if (bus.d_req) begin
          m_req_s = 1'b1;
          owner_s = 1'b1;
        end else if (bus.i_req) begin
          m_req_s = 1'b1;
          owner_s = 1'b0;
        end else begin
          m_req_s = 1'b0;
        end
        if (m_req_s && !bus.m_gnt) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        owner_s = owner_r;
        m_req_s = owner_r ? bus.d_req : bus.i_req;
        if (bus.m_gnt || !m_req_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and locked owner.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
    end
  end

  // Grant-order ID FIFO: one bit per outstanding transaction (0=instr, 1=data).
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      fifo_r   <= {OUTST_DEPTH{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        fifo_r[wr_ptr_r] <= owner_s;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky protocol error: stray grant or a response with nothing outstanding.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      err_r <= 1'b0;
    end else if ((bus.m_gnt && !m_req_s) || (bus.m_r_valid && (cnt_r == {CNT_W{1'b0}}))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Output routing; everything is forced low while reset is asserted.
  always_comb begin
    bus.m_req     = 1'b0;
    bus.m_adr     = {ADR_W{1'b0}};
    bus.m_we      = 1'b0;
    bus.m_wdata   = {DATA_W{1'b0}};
    bus.i_gnt     = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.i_r_valid = 1'b0;
    bus.d_r_valid = 1'b0;
    bus.i_rdata   = {DATA_W{1'b0}};
    bus.d_rdata   = {DATA_W{1'b0}};
    bus.err       = err_r;
    if (res) begin
      if (m_req_s) begin
        bus.m_req   = 1'b1;
        bus.m_adr   = owner_s ? bus.d_adr : bus.i_adr;
        bus.m_we    = owner_s & bus.d_we;
        bus.m_wdata = owner_s ? bus.d_wdata : {DATA_W{1'b0}};
      end else begin
        bus.m_req = 1'b0;
      end
      bus.i_gnt = accept_s & ~owner_s;
      bus.d_gnt = accept_s & owner_s;
      if (pop_s) begin
        bus.i_r_valid = ~head_s;
        bus.d_r_valid = head_s;
        bus.i_rdata   = head_s ? {DATA_W{1'b0}} : bus.m_rdata;
        bus.d_rdata   = head_s ? bus.m_rdata : {DATA_W{1'b0}};
      end else begin
        bus.i_r_valid = 1'b0;
      end
    end else begin
      bus.err = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int DEPTH = 2;

  logic clk;
  logic res;
  int   n_vec;
  int   n_err;

  // Reference model state: grant-order queue, requester awaiting acceptance, last winner, sticky error.
  bit   q[$];
  int   hold_own;
  bit   last_win;
  bit   err_m;
  bit   g_i;
  bit   g_d;

  mem_port_arbiter_if #(.ADR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADR_W(32), .DATA_W(32), .OUTST_DEPTH(DEPTH)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                        input logic dw, input logic [31:0] dd, input logic mg, input logic mv,
                        input logic [31:0] md);
    bus.i_req = ir; bus.i_adr = ia; bus.d_req = dr; bus.d_adr = da; bus.d_we = dw;
    bus.d_wdata = dd; bus.m_gnt = mg; bus.m_r_valid = mv; bus.m_rdata = md;
  endtask

  // Who the memory port should be serving this cycle, from the arbitration rules.
  task automatic model_sel(output bit mreq, output bit own);
    own  = 1'b0;
    mreq = 1'b0;
    if (hold_own >= 0) begin
      own  = hold_own[0];
      mreq = own ? bus.d_req : bus.i_req;
    end else if (q.size() >= DEPTH || (!bus.i_req && !bus.d_req)) begin
      mreq = 1'b0;
    end else if (bus.i_req && bus.d_req) begin
      mreq = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      own = !last_win;
`else
      own = 1'b1;
`endif
    end else begin
      mreq = 1'b1;
      own  = bus.d_req;
    end
  endtask

  task automatic step();
    bit mreq, own, acc, pop, head;
    #1;
    model_sel(mreq, own);
    acc  = mreq && bus.m_gnt;
    pop  = bus.m_r_valid && (q.size() > 0);
    head = pop ? q[0] : 1'b0;
    chk("m_req", 32'(bus.m_req), 32'(mreq));
    chk("m_adr", bus.m_adr, mreq ? (own ? bus.d_adr : bus.i_adr) : 32'h0);
    chk("m_we", 32'(bus.m_we), 32'(mreq && own && bus.d_we));
    chk("m_wdata", bus.m_wdata, (mreq && own) ? bus.d_wdata : 32'h0);
    chk("i_gnt", 32'(bus.i_gnt), 32'(acc && !own));
    chk("d_gnt", 32'(bus.d_gnt), 32'(acc && own));
    chk("i_r_valid", 32'(bus.i_r_valid), 32'(pop && !head));
    chk("d_r_valid", 32'(bus.d_r_valid), 32'(pop && head));
    chk("i_rdata", bus.i_rdata, (pop && !head) ? bus.m_rdata : 32'h0);
    chk("d_rdata", bus.d_rdata, (pop && head) ? bus.m_rdata : 32'h0);
    chk("err", 32'(bus.err), 32'(err_m));
    if (bus.m_gnt && !mreq) err_m = 1'b1;
    if (bus.m_r_valid && q.size() == 0) err_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(own);
      hold_own = -1;
      last_win = own;
    end else if (mreq) begin
      hold_own = int'(own);
    end else begin
      hold_own = -1;
    end
    g_i = acc && !own;
    g_d = acc && own;
  endtask

  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                     input logic dw, input logic [31:0] dd, input logic mg, input logic mv,
                     input logic [31:0] md);
    @(negedge clk);
    set_in(ir, ia, dr, da, dw, dd, mg, mv, md);
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m_req"}, 32'(bus.m_req), 32'h0);
    chk({tag, "_m_adr"}, bus.m_adr, 32'h0);
    chk({tag, "_m_we"}, 32'(bus.m_we), 32'h0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 32'h0);
    chk({tag, "_gnt"}, 32'({bus.i_gnt, bus.d_gnt}), 32'h0);
    chk({tag, "_r_valid"}, 32'({bus.i_r_valid, bus.d_r_valid}), 32'h0);
    chk({tag, "_i_rdata"}, bus.i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
  endtask

  // Asserts reset at the current time (inputs left as they are), then releases on a falling edge.
  task automatic do_reset();
    res = 1'b0;
    #1;
    chk_zero("rst");
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    q.delete();
    hold_own = -1;
    last_win = 1'b1;
    err_m    = 1'b0;
    g_i      = 1'b0;
    g_d      = 1'b0;
    @(negedge clk);
    chk_zero("rst_hold");
    res = 1'b1;
  endtask

  initial begin
    bit mreq, own;
    n_vec = 0;
    n_err = 0;
    res   = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_reset();

    // Single fetch, response two cycles after acceptance.
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("fetch_i_gnt", 32'(bus.i_gnt), 32'h1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00500093);
    chk("fetch_i_rdata", bus.i_rdata, 32'h00500093);
    chk("fetch_d_r_valid", 32'(bus.d_r_valid), 32'h0);

    // Conflict right after reset.
    @(negedge clk); #2; do_reset();
    cyc(1'b1, 32'h300, 1'b1, 32'h2000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("conf_m_adr", bus.m_adr, 32'h300);
    chk("conf_i_gnt", 32'(bus.i_gnt), 32'h1);
    cyc(1'b0, 32'h0, 1'b1, 32'h2000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    chk("conf2_m_adr", bus.m_adr, 32'h2000);
    chk("conf2_m_we", 32'(bus.m_we), 32'h1);
`else
    chk("conf_m_adr", bus.m_adr, 32'h2000);
    chk("conf_m_we", 32'(bus.m_we), 32'h1);
    chk("conf_d_gnt", 32'(bus.d_gnt), 32'h1);
    cyc(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("conf2_m_adr", bus.m_adr, 32'h300);
    chk("conf2_i_gnt", 32'(bus.i_gnt), 32'h1);
`endif
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2);

    // Lock: instr held for three cycles, data arrives but must wait.
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'h440, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h440, 1'b1, 32'h3000, 1'b0, 32'h5, 1'b0, 1'b0, 32'h0);
    chk("lock_m_adr", bus.m_adr, 32'h440);
    cyc(1'b1, 32'h440, 1'b1, 32'h3000, 1'b0, 32'h5, 1'b1, 1'b0, 32'h0);
    chk("lock_i_gnt", 32'(bus.i_gnt), 32'h1);
    chk("lock_d_gnt", 32'(bus.d_gnt), 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'h3000, 1'b0, 32'h5, 1'b1, 1'b0, 32'h0);
    chk("lock_d_after", 32'(bus.d_gnt), 32'h1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);

    // Ordering and full masking.
    cyc(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("full_m_req", 32'(bus.m_req), 32'h0);
    cyc(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11);
    chk("ord_i_rdata", bus.i_rdata, 32'h11);
    chk("ord_full_pop_m_req", 32'(bus.m_req), 32'h0);
    cyc(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22);
    chk("ord_d_rdata", bus.d_rdata, 32'h22);
    chk("ord_m_req_back", 32'(bus.m_req), 32'h1);
    cyc(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h33);

    // Response with nothing outstanding.
    @(negedge clk); #2; do_reset();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77);
    chk("err_rv", 32'({bus.i_r_valid, bus.d_r_valid}), 32'h0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("err_sticky", 32'(bus.err), 32'h1);
    @(negedge clk); #2; do_reset();

    // Asynchronous reset while holding with one outstanding, then a stale response.
    cyc(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 32'h99, 1'b0, 1'b0, 32'h0);
    chk("mid_m_req", 32'(bus.m_req), 32'h1);
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 32'h99, 1'b0, 1'b1, 32'hAA);
    #3;
    do_reset();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("stale_err", 32'(bus.err), 32'h1);

    // Randomized traffic from well-behaved requesters and memory.
    @(negedge clk); #2; do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!bus.i_req || g_i) begin
        bus.i_req = 1'($urandom_range(0, 1));
        bus.i_adr = $urandom;
      end
      if (!bus.d_req || g_d) begin
        bus.d_req   = 1'($urandom_range(0, 1));
        bus.d_adr   = $urandom;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_wdata = $urandom;
      end
      model_sel(mreq, own);
      bus.m_gnt     = mreq ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.m_r_valid = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
      bus.m_rdata   = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one req/gnt/r_valid memory port between the processor's instruction fetch interface and its data load/store interface.
- Selects one requester per transaction and forwards its request to the memory port.
- Records the grant order in a small ID FIFO so that each response (r_valid + rdata) goes back to the requester that issued it.
- Sits between the processor core and a single unified memory.

Parameters:
- ADR_W, 32, address width.
- DATA_W, 32, read/write data width.
- OUTST_DEPTH, 2, maximum accepted-but-unanswered transactions; size of the ID FIFO; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  asynchronous active-low reset.
- i_req  in  1  instruction fetch request.
- i_adr  in  ADR_W  instruction address.
- i_gnt  out  1  instruction request accepted.
- i_r_valid  out  1  instruction read data valid.
- i_rdata  out  DATA_W  instruction read data.
- d_req  in  1  data request.
- d_adr  in  ADR_W  data address.
- d_we  in  1  data write enable.
- d_wdata  in  DATA_W  data write value.
- d_gnt  out  1  data request accepted.
- d_r_valid  out  1  data response valid (reads and writes).
- d_rdata  out  DATA_W  data read value.
- m_req  out  1  memory request.
- m_adr  out  ADR_W  memory address.
- m_we  out  1  memory write enable.
- m_wdata  out  DATA_W  memory write value.
- m_gnt  in  1  memory accepted request.
- m_r_valid  in  1  memory response valid.
- m_rdata  in  DATA_W  memory read data.
- err  out  1  sticky protocol error flag.

Behaviour:
- Requester protocol: a requester holds req and its payload stable until it sees gnt. A transaction is accepted in the cycle where gnt=1 and req=1.
- Every accepted transaction, including writes, receives exactly one r_valid, in grant order.
- Instruction requests are always m_we=0. m_wdata is don't-care for instruction requests; it is driven 0.

FSM states:
- IDLE: no request is presented to memory.
  - If the FIFO is full: m_req=0 and stay in IDLE.
  - Otherwise pick a winner. Default priority: data over instruction.
  - Drive the winner's payload onto m_* combinationally in the same cycle, with m_req=1.
  - If m_gnt=1 that cycle, the transaction is accepted and the FSM stays in IDLE.
  - If m_gnt=0, latch the owner and go to HOLD.
- HOLD: the owner is locked and m_* follows the owner's inputs.
  - No switching is allowed, even if a higher-priority request arrives.
  - On m_gnt=1, return to IDLE.
- Grant routing: m_gnt is routed only to the current owner's gnt. The other gnt is 0.
- On acceptance, push the owner ID (0=instr, 1=data) into the FIFO. Zero-cycle arbitration; gnt has the same latency as m_gnt.
- Response routing: on m_r_valid=1, pop the FIFO head.
  - Drive that requester's r_valid=1 and rdata=m_rdata in the same cycle (combinational).
  - The non-selected requester gets r_valid=0 and rdata=0.
- FIFO full: the full check uses the registered count. If push and pop happen in the same cycle while full, the request is still masked that cycle.
- Simultaneous push and pop when the FIFO is not full: the count is unchanged and the pointers advance mod OUTST_DEPTH.
- Error cases: err is set and holds until reset.
  - m_r_valid=1 with an empty FIFO: response discarded, both r_valid=0.
  - m_gnt=1 while m_req=0: m_gnt ignored.
- Reset (res=0, asynchronous):
  - FSM goes to IDLE; FIFO count and pointers are 0; err=0.
  - All outputs are 0: m_req, m_we, m_adr, m_wdata, both gnt, both r_valid and both rdata.
  - A reset mid-transaction drops all outstanding IDs. Responses arriving after reset raise err.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-winner register is updated on each acceptance.
  - In IDLE with both requests present, the requester that did not win last is chosen.
  - The register resets to 1 (data), so the first conflict goes to instr.
- Undefined: fixed priority, data over instruction; the register is not implemented.
- HOLD locking, FIFO and response behaviour are identical in both builds.

Test Plan:
- Single fetch: i_req=1, i_adr=0x100, m_gnt=1 same cycle, m_r_valid=1 two cycles later with m_rdata=0x00500093 -> i_gnt pulses once; i_r_valid=1 with i_rdata=0x00500093; d_gnt and d_r_valid stay 0.
- Conflict: i_req and d_req both 1, d_adr=0x2000, d_we=1, d_wdata=0xDEADBEEF, m_gnt=1 -> m_adr=0x2000, m_we=1, d_gnt=1, i_gnt=0. The next cycle, instr is granted with m_adr=i_adr. With MEM_ARB_ROUND_ROBIN_EN, the first conflict grants instr instead.
- Lock: i_req alone with m_gnt=0 for 3 cycles, then d_req rises -> m_adr stays i_adr until m_gnt=1, i_gnt=1 that cycle, then data is granted.
- Ordering and full: OUTST_DEPTH=2; grant instr then data with no responses; a third request sees m_req=0. Two m_r_valid pulses (0x11, 0x22) -> i_rdata=0x11 first, then d_rdata=0x22; m_req reasserts the cycle after the count drops below 2.
- Errors: m_r_valid=1 with the FIFO empty -> err=1 and both r_valid=0; err stays 1 until res=0.
- Reset mid-op: res=0 asynchronously while in HOLD with 1 outstanding -> all outputs 0 immediately. After release, a stale m_r_valid sets err.
